// File: rtl/pwm_button_conditioner_if.sv
// Button-to-PWM signal bundle: raw buttons in, duty step pulses and held levels out.
interface pwm_button_conditioner_if;
    logic btn_inc;
    logic btn_dec;
    logic duty_inc;
    logic duty_dec;
    logic inc_held;
    logic dec_held;

    // Side that presses the buttons and consumes the step pulses.
    modport master (
        output btn_inc,
        output btn_dec,
        input  duty_inc,
        input  duty_dec,
        input  inc_held,
        input  dec_held
    );

    // Conditioner side.
    modport slave (
        input  btn_inc,
        input  btn_dec,
        output duty_inc,
        output duty_dec,
        output inc_held,
        output dec_held
    );
endinterface

// File: rtl/pwm_button_conditioner.sv
// Synchronises, debounces and edge-detects the two duty buttons, producing
// one-cycle increment/decrement pulses with optional hold-to-repeat and an
// interlock that silences both outputs while both buttons are held.
module pwm_button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned REPEAT_DELAY    = 16,
    parameter int unsigned REPEAT_RATE     = 8,
    parameter int unsigned CNT_W           = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    pwm_button_conditioner_if.slave  bus
);

    localparam bit               RPT_EN    = (REPEAT_DELAY != 0);
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RPT_FIRST = RPT_EN ? CNT_W'(REPEAT_DELAY - 1) : '0;
    localparam logic [CNT_W-1:0] RPT_NEXT  = CNT_W'(REPEAT_RATE - 1);

    // Channel 0 is the increase button, channel 1 the decrease button.
    logic [1:0]       btn_raw;
    logic [1:0]       s1_q, s2_q;
    logic [1:0]       stable_q, stable_d;
    logic [CNT_W-1:0] db_cnt_q  [2];
    logic [CNT_W-1:0] db_cnt_d  [2];
    logic [CNT_W-1:0] rpt_cnt_q [2];
    logic [CNT_W-1:0] rpt_cnt_d [2];
    logic [1:0]       press, release_ev, rpt_fire, raw_pulse, active;
    logic [1:0]       duty_q, duty_d;

    assign btn_raw = {bus.btn_dec, bus.btn_inc};

    // Debounce, repeat scheduling and interlock, all from pre-edge state.
    always_comb begin
        stable_d   = stable_q;
        press      = '0;
        release_ev = '0;
        rpt_fire   = '0;
        raw_pulse  = '0;
        active     = '0;
        duty_d     = '0;
        for (int i = 0; i < 2; i++) begin
            db_cnt_d[i]  = '0;
            rpt_cnt_d[i] = '0;

            // Any cycle of agreement restarts the stability window.
            if (s2_q[i] != stable_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    stable_d[i]   = ~stable_q[i];
                    press[i]      = ~stable_q[i];
                    release_ev[i] = stable_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end

            rpt_fire[i] = RPT_EN && stable_q[i] && !release_ev[i] && (rpt_cnt_q[i] == '0);

            if (press[i]) begin
                rpt_cnt_d[i] = RPT_FIRST;
            end else if (!RPT_EN || !stable_q[i] || release_ev[i]) begin
                rpt_cnt_d[i] = '0;
            end else if (rpt_cnt_q[i] == '0) begin
                rpt_cnt_d[i] = RPT_NEXT;
            end else begin
                rpt_cnt_d[i] = rpt_cnt_q[i] - 1'b1;
            end

            raw_pulse[i] = press[i] | rpt_fire[i];
            // A button counts as held for the interlock if it is already
            // stable-high or becoming so on this edge, so simultaneous presses
            // cancel each other.
            active[i]    = stable_q[i] | press[i];
        end
        duty_d[0] = raw_pulse[0] & ~active[1];
        duty_d[1] = raw_pulse[1] & ~active[0];
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q     <= '0;
            s2_q     <= '0;
            stable_q <= '0;
            duty_q   <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt_q[i]  <= '0;
                rpt_cnt_q[i] <= '0;
            end
        end else begin
            s1_q     <= btn_raw;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            duty_q   <= duty_d;
            for (int i = 0; i < 2; i++) begin
                db_cnt_q[i]  <= db_cnt_d[i];
                rpt_cnt_q[i] <= rpt_cnt_d[i];
            end
        end
    end

    assign bus.duty_inc = duty_q[0];
    assign bus.duty_dec = duty_q[1];
    assign bus.inc_held = stable_q[0];
    assign bus.dec_held = stable_q[1];

endmodule

// File: tb/tb_pwm_button_conditioner.sv
// Directed bench for pwm_button_conditioner: default build (a) and a build
// with auto-repeat disabled (b).
module tb_pwm_button_conditioner;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pwm_button_conditioner_if bus_a ();
    pwm_button_conditioner_if bus_b ();

    pwm_button_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (16),
        .REPEAT_RATE     (8),
        .CNT_W           (24)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    pwm_button_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (0),
        .REPEAT_RATE     (8),
        .CNT_W           (24)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int inc_q [$];
    int dec_q [$];
    int b_inc_q [$];
    int b_dec_q [$];
    bit dec_held_seen;

    // Advance one edge, sample 1 time unit later and log pulse edges.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (bus_a.duty_inc === 1'b1) inc_q.push_back(cyc);
        if (bus_a.duty_dec === 1'b1) dec_q.push_back(cyc);
        if (bus_b.duty_inc === 1'b1) b_inc_q.push_back(cyc);
        if (bus_b.duty_dec === 1'b1) b_dec_q.push_back(cyc);
        if (bus_a.dec_held === 1'b1) dec_held_seen = 1'b1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        inc_q.delete();
        dec_q.delete();
        b_inc_q.delete();
        b_dec_q.delete();
    endtask

    function automatic int q_at(input int q [$], input int k);
        return (k < q.size()) ? q[k] : -1;
    endfunction

    int r, c, a, s, b;
    int rpt_off [7] = '{6, 22, 30, 38, 46, 54, 62};

    initial begin
        bus_a.btn_inc = 1'b1;
        bus_a.btn_dec = 1'b1;
        bus_b.btn_inc = 1'b0;
        bus_b.btn_dec = 1'b0;
        dec_held_seen = 1'b0;

        // Reset with both buttons pressed: everything must stay low.
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("reset_outs_a", int'({bus_a.duty_inc, bus_a.duty_dec,
                                      bus_a.inc_held, bus_a.dec_held}), 0);
            chk("reset_outs_b", int'({bus_b.duty_inc, bus_b.duty_dec,
                                      bus_b.inc_held, bus_b.dec_held}), 0);
        end
        rst = 1'b0;
        r = cyc;
        clear_logs();
        ticks(5);
        chk("rst_held_early", int'(bus_a.inc_held), 0);
        tick();
        chk("rst_inc_held_at6", int'(bus_a.inc_held), 1);
        chk("rst_dec_held_at6", int'(bus_a.dec_held), 1);
        ticks(30);
        // Both stabilise on the same edge and stay held: interlocked.
        chk("rst_inc_pulses", inc_q.size(), 0);
        chk("rst_dec_pulses", dec_q.size(), 0);
        bus_a.btn_inc = 1'b0;
        bus_a.btn_dec = 1'b0;
        ticks(10);
        chk("rst_release_held", int'({bus_a.inc_held, bus_a.dec_held}), 0);

        // Clean press of 10 cycles.
        clear_logs();
        c = cyc;
        bus_a.btn_inc = 1'b1;
        ticks(10);
        bus_a.btn_inc = 1'b0;
        ticks(5);
        chk("clean_held_before_fall", int'(bus_a.inc_held), 1);
        tick();
        chk("clean_held_after_fall", int'(bus_a.inc_held), 0);
        ticks(14);
        chk("clean_inc_count", inc_q.size(), 1);
        chk("clean_inc_edge", q_at(inc_q, 0), c + 6);
        chk("clean_dec_count", dec_q.size(), 0);

        // Bounce on btn_dec, then a too-short 3-cycle press.
        clear_logs();
        dec_held_seen = 1'b0;
        bus_a.btn_dec = 1'b1; tick();
        bus_a.btn_dec = 1'b0; tick();
        bus_a.btn_dec = 1'b1; tick();
        bus_a.btn_dec = 1'b0; tick();
        ticks(10);
        chk("bounce_dec_count", dec_q.size(), 0);
        bus_a.btn_dec = 1'b1;
        ticks(3);
        bus_a.btn_dec = 1'b0;
        ticks(10);
        chk("short_dec_count", dec_q.size(), 0);
        chk("bounce_dec_held_seen", int'(dec_held_seen), 0);

        // Hold btn_inc 60 cycles: press plus six repeats.
        clear_logs();
        a = cyc;
        bus_a.btn_inc = 1'b1;
        ticks(60);
        bus_a.btn_inc = 1'b0;
        ticks(20);
        chk("repeat_count", inc_q.size(), 7);
        for (int k = 0; k < 7; k++) begin
            chk($sformatf("repeat_edge%0d", k), q_at(inc_q, k), a + rpt_off[k]);
        end
        chk("repeat_held_end", int'(bus_a.inc_held), 0);
        chk("repeat_dec_count", dec_q.size(), 0);

        // Simultaneous press, then release dec: inc resumes at slot s+54.
        clear_logs();
        s = cyc;
        bus_a.btn_inc = 1'b1;
        bus_a.btn_dec = 1'b1;
        ticks(40);
        chk("simul_inc_held", int'(bus_a.inc_held), 1);
        chk("simul_inc_pulses", inc_q.size(), 0);
        chk("simul_dec_pulses", dec_q.size(), 0);
        bus_a.btn_dec = 1'b0;
        ticks(20);
        bus_a.btn_inc = 1'b0;
        ticks(20);
        chk("resume_inc_count", inc_q.size(), 2);
        chk("resume_inc_edge0", q_at(inc_q, 0), s + 54);
        chk("resume_inc_edge1", q_at(inc_q, 1), s + 62);
        chk("resume_dec_pulses", dec_q.size(), 0);

        // Repeat disabled build: one pulse for a long hold.
        clear_logs();
        b = cyc;
        bus_b.btn_dec = 1'b1;
        ticks(100);
        bus_b.btn_dec = 1'b0;
        ticks(10);
        chk("norpt_dec_count", b_dec_q.size(), 1);
        chk("norpt_dec_edge", q_at(b_dec_q, 0), b + 6);
        chk("norpt_inc_count", b_inc_q.size(), 0);
        chk("norpt_held_end", int'(bus_b.dec_held), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
